eth_tx_arb: RTL and testbench
=============================

ETH_TX_ARB -- requirements
Module: eth_tx_arb

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, meaning number of user TX byte-stream channels (legal 1..8).
REQ-002 SHALL have parameter DEPTH, default 64, meaning per-channel packet buffer size in bytes (power of 2, 16..2048).
REQ-003 SHALL have port Clk, input, 1, meaning single clock (Eth_Clk domain); one clock, no other clock ports.
REQ-004 SHALL have port Rstn, input, 1, meaning reset, asynchronous assert, active-low.
REQ-005 SHALL have port Ch_Byte, input, NUM_CH*8, meaning channel c payload byte in bits [8c+7:8c].
REQ-006 SHALL have port Ch_Byte_Valid, input, NUM_CH, meaning per-channel byte strobe.
REQ-007 SHALL have port Ch_Pkt_Rdy, input, NUM_CH, meaning per-channel one-cycle end-of-packet strobe.
REQ-008 SHALL have port Ch_Busy, output, NUM_CH, meaning channel holds a committed packet; writes ignored.
REQ-009 SHALL have port Eth_Byte, output, 8, meaning byte to eth_tx.
REQ-010 SHALL have port Eth_Byte_Valid, output, 1, meaning Eth_Byte strobe to eth_tx.
REQ-011 SHALL have port Eth_Pkt_Rdy, output, 1, meaning one-cycle send kickoff to eth_tx.
REQ-012 SHALL have port Tx_En, input, 1, meaning eth_tx Tx_En, used as frame-in-flight indication.
REQ-013 SHALL have port Drop_Cnt, output, 16, meaning dropped-packet count (see Configuration).

Function
REQ-014 SHALL write each Ch_Byte_Valid byte into channel buffer at write count, count incrementing by 1, while Ch_Busy[c]=0.
REQ-015 SHALL, on Ch_Pkt_Rdy[c] with count 1..DEPTH, set Ch_Busy[c] next cycle; Byte_Valid and Pkt_Rdy in same cycle includes that byte as last.
REQ-016 SHALL discard a packet (count reset to 0, no Ch_Busy) on Pkt_Rdy with count 0 or after any byte arrived with count=DEPTH (overflow); overflow bytes not stored.
REQ-017 SHALL implement FSM IDLE -> ARB -> DRAIN -> KICK -> WAIT_TX -> IDLE.
REQ-018 IDLE: go ARB when any Ch_Busy set; ARB: grant round-robin, search starting at (last granted+1) mod NUM_CH, first search after reset starts at 0.
REQ-019 DRAIN: output granted buffer bytes 0..L-1 on L consecutive cycles with Eth_Byte_Valid=1, no gaps; buffer read latency 1 cycle.
REQ-020 SHALL, from idle, assert first Eth_Byte_Valid exactly 3 cycles after the accepted Ch_Pkt_Rdy cycle.
REQ-021 KICK: Eth_Pkt_Rdy=1 for exactly one cycle, the cycle after last byte.
REQ-022 WAIT_TX: wait for Tx_En rise then fall; on fall clear granted Ch_Busy and count, return IDLE; if Tx_En not high within 255 cycles of KICK, same release (no hang).
REQ-023 New channel packets SHALL be accepted on non-granted channels during any state; granted channel ignores writes until released.
REQ-024 Eth_Byte SHALL be 0 whenever Eth_Byte_Valid=0.

Reset
REQ-025 Rstn low SHALL immediately clear FSM to IDLE, all counts, Ch_Busy=0, Eth_Byte=0, Eth_Byte_Valid=0, Eth_Pkt_Rdy=0, Drop_Cnt=0, RR pointer to 0; in-progress packets lost; buffer RAM contents not reset.

Configuration
REQ-026 With ETH_TX_ARB_DROP_CNT_EN defined, Drop_Cnt SHALL increment by 1 per REQ-016 discard, saturating at 16'hFFFF; without it Drop_Cnt SHALL be constant 0 and no counter logic synthesised.

Structure
REQ-027 eth_pkg SHALL hold FSM state typedef (IDLE, ARB, DRAIN, KICK, WAIT_TX) and TX_WAIT_TIMEOUT=255 constant.
REQ-028 Per-channel buffer+count+busy SHALL be sub-module eth_tx_arb_buf, generated NUM_CH times.

Verification
REQ-029 NUM_CH=2: ch0 writes 0x01..0x0A then Pkt_Rdy -> 10 contiguous bytes 0x01..0x0A, first 3 cycles after Pkt_Rdy, Eth_Pkt_Rdy pulse next cycle.
REQ-030 Both channels Pkt_Rdy same cycle, repeated 4 times -> grants ch0,ch1,ch0,ch1; Ch_Busy[c] drops at each Tx_En fall.
REQ-031 DEPTH=16: 17 bytes then Pkt_Rdy -> nothing sent, Drop_Cnt=1 (macro on) / 0 (macro off); Pkt_Rdy with 0 bytes -> nothing sent.
REQ-032 Tx_En held 0 after KICK -> release 255 cycles later, next pending channel served.
REQ-033 Rstn low during DRAIN byte 5 -> all outputs 0 same cycle; after release, ch1 new packet sent normally.

Source files
------------

// File: rtl/eth_pkg.sv
// eth_pkg: FSM state type and transmit-wait timeout shared by eth_tx_arb.
package eth_pkg;
  typedef enum logic [2:0] {IDLE, ARB, DRAIN, KICK, WAIT_TX} state_t;
  localparam int TX_WAIT_TIMEOUT = 255;
endpackage

// File: rtl/eth_tx_arb_if.sv
// eth_tx_arb_if: channel-side and eth_tx-side signal bundle around eth_tx_arb.
interface eth_tx_arb_if #(parameter int NUM_CH = 2);
  logic [NUM_CH*8-1:0] ch_byte;
  logic [NUM_CH-1:0] ch_byte_valid, ch_pkt_rdy, ch_busy;
  logic [7:0] eth_byte;
  logic eth_byte_valid, eth_pkt_rdy, tx_en;
  logic [15:0] drop_cnt;
  modport master (output ch_byte, ch_byte_valid, ch_pkt_rdy, tx_en,
                  input ch_busy, eth_byte, eth_byte_valid, eth_pkt_rdy, drop_cnt);
  modport slave (input ch_byte, ch_byte_valid, ch_pkt_rdy, tx_en,
                 output ch_busy, eth_byte, eth_byte_valid, eth_pkt_rdy, drop_cnt);
endinterface

// File: rtl/eth_tx_arb_buf.sv
// eth_tx_arb_buf: one channel's packet buffer, write count, overflow flag and busy latch.
module eth_tx_arb_buf #(
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          Clk,
  input  logic          Rstn,
  input  logic [7:0]    i_byte,
  input  logic          i_byte_valid,
  input  logic          i_pkt_rdy,
  input  logic          i_rel,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data,
  output logic [AW:0]   o_len,
  output logic          o_busy,
  output logic          o_drop
);
  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rd_data;
  logic [AW:0] r_cnt, w_cnt_n;
  logic r_busy, r_ovf, w_wr, w_full, w_bad;
  assign w_full = r_cnt == (AW+1)'(DEPTH);
  assign w_wr = i_byte_valid && !r_busy;
  assign w_cnt_n = r_cnt + (AW+1)'(w_wr && !w_full);
  // a byte arriving on a full buffer poisons the packet until its Pkt_Rdy
  assign w_bad = r_ovf || (w_wr && w_full) || w_cnt_n == '0;
  assign o_drop = i_pkt_rdy && !r_busy && w_bad;
  assign o_busy = r_busy;
  assign o_len = r_cnt;
  assign o_rd_data = r_rd_data;
  always_ff @(posedge Clk or negedge Rstn)
    if (!Rstn) begin
      r_cnt <= '0;
      r_busy <= 1'b0;
      r_ovf <= 1'b0;
    end else if (i_rel) begin
      r_cnt <= '0;
      r_busy <= 1'b0;
      r_ovf <= 1'b0;
    end else if (!r_busy) begin
      r_busy <= i_pkt_rdy && !w_bad;
      r_cnt <= (i_pkt_rdy && w_bad) ? '0 : w_cnt_n;
      r_ovf <= !i_pkt_rdy && (r_ovf || (w_wr && w_full));
    end
  always_ff @(posedge Clk) begin
    if (w_wr && !w_full) r_mem[r_cnt[AW-1:0]] <= i_byte;
    r_rd_data <= r_mem[i_rd_addr];
  end
endmodule

// File: rtl/eth_tx_arb.sv
// eth_tx_arb: round-robin arbiter draining per-channel packet buffers into eth_tx.
// Define ETH_TX_ARB_DROP_CNT_EN to count discarded packets on Drop_Cnt.
module eth_tx_arb
  import eth_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DEPTH = 64
) (
  input  logic                Clk,
  input  logic                Rstn,
  input  logic [NUM_CH*8-1:0] Ch_Byte,
  input  logic [NUM_CH-1:0]   Ch_Byte_Valid,
  input  logic [NUM_CH-1:0]   Ch_Pkt_Rdy,
  output logic [NUM_CH-1:0]   Ch_Busy,
  output logic [7:0]          Eth_Byte,
  output logic                Eth_Byte_Valid,
  output logic                Eth_Pkt_Rdy,
  input  logic                Tx_En,
  output logic [15:0]         Drop_Cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int GW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  state_t r_state, w_next;
  logic [GW-1:0] r_gnt, r_rr, w_gnt;
  logic [AW:0] r_ptr;
  logic [7:0] r_to;
  logic r_seen, w_done;
  logic [AW-1:0] w_rd_addr;
  logic [7:0] w_rd_data [NUM_CH];
  logic [AW:0] w_len [NUM_CH];
  logic [NUM_CH-1:0] w_drop, w_rel;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign w_rel[c] = r_state == WAIT_TX && w_done && r_gnt == GW'(c);
    eth_tx_arb_buf #(.DEPTH(DEPTH)) u_buf (
      .Clk, .Rstn,
      .i_byte(Ch_Byte[8*c+:8]), .i_byte_valid(Ch_Byte_Valid[c]), .i_pkt_rdy(Ch_Pkt_Rdy[c]),
      .i_rel(w_rel[c]), .i_rd_addr(w_rd_addr), .o_rd_data(w_rd_data[c]),
      .o_len(w_len[c]), .o_busy(Ch_Busy[c]), .o_drop(w_drop[c])
    );
  end
  // descending scan so the busy channel closest after r_rr wins
  always_comb begin
    logic [GW-1:0] idx;
    idx = '0;
    w_gnt = r_rr;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = GW'((int'(r_rr) + i) % NUM_CH);
      if (Ch_Busy[idx]) w_gnt = idx;
    end
  end
  // release on Tx_En fall, or on timeout if Tx_En never rose
  assign w_done = !Tx_En && (r_seen || r_to == 8'(TX_WAIT_TIMEOUT));
  always_comb begin
    w_next = r_state;
    w_rd_addr = r_state == DRAIN ? AW'(r_ptr + 1'b1) : '0;
    unique case (r_state)
      IDLE:    w_next = |Ch_Busy ? ARB : IDLE;
      ARB:     w_next = DRAIN;
      DRAIN:   w_next = r_ptr == w_len[r_gnt] - 1'b1 ? KICK : DRAIN;
      KICK:    w_next = WAIT_TX;
      WAIT_TX: w_next = w_done ? IDLE : WAIT_TX;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge Clk or negedge Rstn)
    if (!Rstn) begin
      r_state <= IDLE;
      r_gnt <= '0;
      r_rr <= '0;
      r_ptr <= '0;
      r_to <= '0;
      r_seen <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ARB) begin
        r_gnt <= w_gnt;
        r_rr <= w_gnt == GW'(NUM_CH - 1) ? '0 : w_gnt + 1'b1;
      end
      r_ptr <= r_state == DRAIN ? r_ptr + 1'b1 : '0;
      r_to <= r_state == KICK ? 8'd1 : r_to + 8'(r_to != 8'hFF);
      r_seen <= r_state == WAIT_TX && (r_seen || Tx_En);
    end
  assign Eth_Byte_Valid = r_state == DRAIN;
  assign Eth_Byte = Eth_Byte_Valid ? w_rd_data[r_gnt] : 8'h00;
  assign Eth_Pkt_Rdy = r_state == KICK;
`ifdef ETH_TX_ARB_DROP_CNT_EN
  logic [15:0] r_drop;
  logic [16:0] w_sum;
  always_comb begin
    w_sum = {1'b0, r_drop};
    for (int i = 0; i < NUM_CH; i++) w_sum = w_sum + 17'(w_drop[i]);
  end
  always_ff @(posedge Clk or negedge Rstn)
    if (!Rstn) r_drop <= '0;
    else r_drop <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
  assign Drop_Cnt = r_drop;
`else
  logic w_unused;
  assign w_unused = |w_drop;
  assign Drop_Cnt = '0;
`endif
endmodule

// File: tb/tb_eth_tx_arb.sv
// tb_eth_tx_arb: directed stimulus with a byte/packet scoreboard and an eth_tx responder model.
module tb_eth_tx_arb;
  localparam int NCH = 2, DEP = 16;
`ifdef ETH_TX_ARB_DROP_CNT_EN
  localparam int DROP_EN = 1;
`else
  localparam int DROP_EN = 0;
`endif
  typedef struct {int ch; int len;} pkt_t;
  logic clk = 0, rstn = 0, tx_auto = 1;
  int total = 0, bad = 0, cyc = 0;
  int t_rdy = 0, t_first = 0, t_last = 0, t_kick = 0, t_rel = 0;
  int seen_bytes = 0, bytes_out = 0, kicks = 0, k0 = 0, b0 = 0;
  byte unsigned exp_b[$];
  pkt_t exp_p[$];
  pkt_t p;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  eth_tx_arb_if #(.NUM_CH(NCH)) bus();
  eth_tx_arb #(.NUM_CH(NCH), .DEPTH(DEP)) dut (
    .Clk(clk), .Rstn(rstn), .Ch_Byte(bus.ch_byte), .Ch_Byte_Valid(bus.ch_byte_valid),
    .Ch_Pkt_Rdy(bus.ch_pkt_rdy), .Ch_Busy(bus.ch_busy), .Eth_Byte(bus.eth_byte),
    .Eth_Byte_Valid(bus.eth_byte_valid), .Eth_Pkt_Rdy(bus.eth_pkt_rdy),
    .Tx_En(bus.tx_en), .Drop_Cnt(bus.drop_cnt)
  );
  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_in();
    bus.ch_byte = '0;
    bus.ch_byte_valid = '0;
    bus.ch_pkt_rdy = '0;
  endtask
  task automatic expect_pkt(int ch, int n, int base);
    for (int i = 0; i < n; i++) exp_b.push_back(8'(base + 64*ch + i));
    exp_p.push_back('{ch, n});
  endtask
  task automatic wr(logic [1:0] mask, int n, int base, bit with_last);
    for (int i = 0; i < n; i++) begin
      tick();
      idle_in();
      for (int c = 0; c < NCH; c++)
        if (mask[c]) begin
          bus.ch_byte[8*c+:8] = 8'(base + 64*c + i);
          bus.ch_byte_valid[c] = 1'b1;
        end
      if (with_last && i == n - 1) begin
        bus.ch_pkt_rdy = mask;
        t_rdy = cyc;
      end
    end
    if (!with_last || n == 0) begin
      tick();
      idle_in();
      bus.ch_pkt_rdy = mask;
      t_rdy = cyc;
    end
    tick();
    idle_in();
  endtask
  task automatic wait_idle(int lim);
    logic done;
    done = 0;
    for (int i = 0; i < lim && !done; i++) begin
      tick();
      done = bus.ch_busy == '0 && exp_b.size() == 0 && !bus.eth_byte_valid && !bus.tx_en;
    end
    chk("wait_idle", done, 1);
  endtask
  always @(negedge clk) begin
    if (!rstn) seen_bytes = 0;
    else begin
      if (bus.eth_byte_valid) begin
        chk("byte_q_nonempty", exp_b.size() > 0, 1);
        if (seen_bytes == 0) t_first = cyc;
        else chk("no_gap", cyc - t_last, 1);
        if (exp_b.size() > 0) chk("eth_byte", bus.eth_byte, exp_b.pop_front());
        t_last = cyc;
        seen_bytes++;
        bytes_out++;
      end else chk("byte_zero_idle", bus.eth_byte, 0);
      if (bus.eth_pkt_rdy) begin
        t_kick = cyc;
        kicks++;
        chk("kick_after_last", cyc - t_last, 1);
        chk("pkt_q_nonempty", exp_p.size() > 0, 1);
        if (exp_p.size() > 0) begin
          p = exp_p.pop_front();
          chk("pkt_len", seen_bytes, p.len);
        end
        seen_bytes = 0;
      end
    end
  end
  initial begin
    int ch;
    forever begin
      @(posedge clk);
      #2;
      if (rstn && bus.eth_pkt_rdy && tx_auto) begin
        ch = exp_p.size() > 0 ? exp_p[0].ch : 0;
        repeat (2) @(posedge clk);
        #1 bus.tx_en = 1'b1;
        repeat (4) @(posedge clk);
        #1 bus.tx_en = 1'b0;
        chk("busy_before_fall", bus.ch_busy[ch], 1);
        @(posedge clk);
        #1;
        chk("busy_drop_at_fall", bus.ch_busy[ch], 0);
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    idle_in();
    bus.tx_en = 1'b0;
    repeat (3) tick();
    chk("rst_busy", bus.ch_busy, 0);
    chk("rst_valid", bus.eth_byte_valid, 0);
    chk("rst_byte", bus.eth_byte, 0);
    chk("rst_kick", bus.eth_pkt_rdy, 0);
    chk("rst_drop", bus.drop_cnt, 0);
    rstn = 1;
    tick();
    expect_pkt(0, 10, 1);
    wr(2'b01, 10, 1, 0);
    chk("busy_set", bus.ch_busy[0], 1);
    wait_idle(300);
    chk("first_latency", t_first - t_rdy, 3);
    expect_pkt(1, 16, 8'h10);
    wr(2'b10, 16, 8'h10, 1);
    wait_idle(300);
    chk("full_latency", t_first - t_rdy, 3);
    rstn = 0;
    repeat (2) tick();
    rstn = 1;
    for (int r = 0; r < 4; r++) begin
      expect_pkt(0, 4, 8'h80 + 4*r);
      expect_pkt(1, 4, 8'h80 + 4*r);
      wr(2'b11, 4, 8'h80 + 4*r, 0);
      wait_idle(300);
    end
    b0 = bytes_out;
    wr(2'b01, 17, 8'h30, 0);
    chk("ovf_no_busy", bus.ch_busy[0], 0);
    chk("drop_ovf", bus.drop_cnt, DROP_EN);
    wr(2'b10, 0, 0, 0);
    chk("empty_no_busy", bus.ch_busy[1], 0);
    chk("drop_empty", bus.drop_cnt, 2*DROP_EN);
    repeat (20) tick();
    chk("nothing_sent", bytes_out - b0, 0);
    expect_pkt(0, 16, 8'h50);
    wr(2'b01, 16, 8'h50, 0);
    wait_idle(300);
    tx_auto = 0;
    k0 = kicks;
    expect_pkt(0, 3, 8'h60);
    wr(2'b01, 3, 8'h60, 0);
    for (int i = 0; i < 50 && kicks == k0; i++) tick();
    chk("kick_seen", kicks - k0, 1);
    expect_pkt(1, 5, 8'h70);
    wr(2'b10, 5, 8'h70, 0);
    wr(2'b01, 4, 8'h99, 0);
    chk("ch1_accepted", bus.ch_busy[1], 1);
    t_rel = -1;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (!bus.ch_busy[0]) begin
        t_rel = cyc;
        break;
      end
    end
    chk("timeout_release", t_rel - t_kick, 256);
    tx_auto = 1;
    wait_idle(300);
    expect_pkt(0, 10, 8'hC0);
    wr(2'b01, 10, 8'hC0, 0);
    repeat (6) @(posedge clk);
    #2;
    chk("byte5_valid", bus.eth_byte_valid, 1);
    chk("byte5_value", bus.eth_byte, 8'hC4);
    rstn = 0;
    #1;
    chk("rst_mid_valid", bus.eth_byte_valid, 0);
    chk("rst_mid_byte", bus.eth_byte, 0);
    chk("rst_mid_kick", bus.eth_pkt_rdy, 0);
    chk("rst_mid_busy", bus.ch_busy, 0);
    chk("rst_mid_drop", bus.drop_cnt, 0);
    exp_b.delete();
    exp_p.delete();
    repeat (2) tick();
    rstn = 1;
    expect_pkt(1, 6, 8'hD0);
    wr(2'b10, 6, 8'hD0, 0);
    wait_idle(300);
    chk("post_rst_latency", t_first - t_rdy, 3);
    chk("queues_empty", exp_b.size() + exp_p.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
